// File: rtl/tnoc_flit_r2r_link.sv
// Register-to-register NoC link with one FIFO per virtual channel, a round-robin
// output arbiter that holds its grant until the downstream accepts, and a sticky protocol-error flag.
module tnoc_flit_r2r_link #(
   parameter int FLIT_WIDTH = 64,
   parameter int CHANNELS   = 2,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CHANNELS-1:0]   i_valid,
   output logic [CHANNELS-1:0]   o_ready,
   input  logic [FLIT_WIDTH-1:0] i_flit,
   output logic [CHANNELS-1:0]   o_valid,
   input  logic [CHANNELS-1:0]   i_ready,
   output logic [FLIT_WIDTH-1:0] o_flit,
   output logic                  o_protocol_error
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int VW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [FLIT_WIDTH-1:0] mem_q [CHANNELS][DEPTH];
   logic [PW-1:0]         wr_ptr_q [CHANNELS];
   logic [PW-1:0]         wr_ptr_d [CHANNELS];
   logic [PW-1:0]         rd_ptr_q [CHANNELS];
   logic [PW-1:0]         rd_ptr_d [CHANNELS];
   logic [CW-1:0]         count_q  [CHANNELS];
   logic [CW-1:0]         count_d  [CHANNELS];

   logic [VW-1:0]         rr_q, rr_d;
   logic [VW-1:0]         grant_q, grant_d;
   logic                  lock_q, lock_d;
   logic                  err_q, err_d;

   logic [VW-1:0]         grant;
   logic [VW-1:0]         cand;
   logic                  any_valid;
   logic                  multi_valid;
   logic [CHANNELS-1:0]   push;
   logic [CHANNELS-1:0]   pop;

   // Handshake: a beat moves on a VC exactly when its valid and ready are both 1
   // at a rising edge; o_ready and o_valid come from registered state only.
   always_comb begin
      grant     = grant_q;
      any_valid = 1'b0;
      cand      = '0;
      if (lock_q) begin
         any_valid = 1'b1;
      end else begin
         for (int i = 1; i <= CHANNELS; i++) begin
            cand = VW'((int'(rr_q) + i) % CHANNELS);
            if (!any_valid && (count_q[cand] != '0)) begin
               grant     = cand;
               any_valid = 1'b1;
            end
         end
      end
   end

   always_comb begin
      o_valid = '0;
      if (any_valid) o_valid[grant] = 1'b1;
      o_flit = mem_q[grant][rd_ptr_q[grant]];
   end

   assign multi_valid      = ($countones(i_valid) > 1);
   assign o_protocol_error = err_q;

   always_comb begin
      o_ready = '0;
      push    = '0;
      pop     = '0;
      for (int v = 0; v < CHANNELS; v++) begin
         o_ready[v]  = (count_q[v] < CW'(DEPTH));
         push[v]     = i_valid[v] & o_ready[v] & ~multi_valid;
         pop[v]      = o_valid[v] & i_ready[v];
         wr_ptr_d[v] = wr_ptr_q[v] + PW'(push[v]);
         rd_ptr_d[v] = rd_ptr_q[v] + PW'(pop[v]);
         count_d[v]  = count_q[v] + CW'(push[v]) - CW'(pop[v]);
      end
   end

   // The grant stays locked while the downstream stalls a presented flit.
   always_comb begin
      rr_d    = rr_q;
      grant_d = grant;
      lock_d  = any_valid & ~i_ready[grant];
      err_d   = err_q | multi_valid;
      if (any_valid && i_ready[grant]) rr_d = grant;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int v = 0; v < CHANNELS; v++) begin
            wr_ptr_q[v] <= '0;
            rd_ptr_q[v] <= '0;
            count_q[v]  <= '0;
         end
         rr_q    <= VW'(CHANNELS - 1);
         grant_q <= '0;
         lock_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         for (int v = 0; v < CHANNELS; v++) begin
            wr_ptr_q[v] <= wr_ptr_d[v];
            rd_ptr_q[v] <= rd_ptr_d[v];
            count_q[v]  <= count_d[v];
         end
         rr_q    <= rr_d;
         grant_q <= grant_d;
         lock_q  <= lock_d;
         err_q   <= err_d;
      end
   end

   // Storage carries no reset; a cleared count makes old entries unreachable.
   always_ff @(posedge clk) begin
      for (int v = 0; v < CHANNELS; v++) begin
         if (rst_n && push[v]) mem_q[v][wr_ptr_q[v]] <= i_flit;
      end
   end

endmodule

// File: tb/tb_tnoc_flit_r2r_link.sv
// Bench for tnoc_flit_r2r_link: per-VC expected queues filled on accepted pushes and
// popped on downstream transfers, with a round-robin/grant-lock reference for o_valid.
module tb_tnoc_flit_r2r_link;

   localparam int FW = 64;

   logic          clk;
   logic          rst_n;
   logic [1:0]    i_valid;
   logic [1:0]    o_ready;
   logic [FW-1:0] i_flit;
   logic [1:0]    o_valid;
   logic [1:0]    i_ready;
   logic [FW-1:0] o_flit;
   logic          o_protocol_error;

   tnoc_flit_r2r_link #(.FLIT_WIDTH(FW), .CHANNELS(2), .DEPTH(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_valid          (i_valid),
      .o_ready          (o_ready),
      .i_flit           (i_flit),
      .o_valid          (o_valid),
      .i_ready          (i_ready),
      .o_flit           (o_flit),
      .o_protocol_error (o_protocol_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [FW-1:0] exp_q0[$];
   logic [FW-1:0] exp_q1[$];
   int            vc_log[$];
   int            m_rr;
   int            m_grant;
   logic          m_lock;
   logic          m_err;
   int            n_checks;
   int            n_pass;

   task automatic check_eq(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic int qsize(input int v);
      return (v == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic logic [FW-1:0] qfront(input int v);
      return (v == 0) ? exp_q0[0] : exp_q1[0];
   endfunction

   task automatic model_reset();
      exp_q0.delete();
      exp_q1.delete();
      m_rr    = 1;
      m_grant = 0;
      m_lock  = 1'b0;
      m_err   = 1'b0;
   endtask

   // One clock: compare outputs at the falling edge, update the reference, then
   // step past the rising edge so the next drive never races the DUT sample.
   task automatic cycle();
      logic [1:0] exp_v;
      logic       hit;
      int         g;
      int         c;
      int         s0;
      int         s1;
      @(negedge clk);
      hit = 1'b0;
      g   = m_grant;
      if (m_lock) hit = 1'b1;
      else begin
         for (int i = 1; i <= 2; i++) begin
            c = (m_rr + i) % 2;
            if (!hit && qsize(c) > 0) begin
               g   = c;
               hit = 1'b1;
            end
         end
      end
      exp_v = hit ? ((g == 0) ? 2'b01 : 2'b10) : 2'b00;
      s0 = exp_q0.size();
      s1 = exp_q1.size();
      check_eq("o_valid", FW'(o_valid), FW'(exp_v));
      check_eq("o_ready", FW'(o_ready), FW'({s1 < 4, s0 < 4}));
      check_eq("o_protocol_error", FW'(o_protocol_error), FW'(m_err));
      if (hit) check_eq("o_flit", o_flit, qfront(g));
      if ((o_valid & i_ready) == 2'b01) vc_log.push_back(0);
      else if ((o_valid & i_ready) == 2'b10) vc_log.push_back(1);
      if (!rst_n) model_reset();
      else begin
         if (hit && i_ready[g]) begin
            if (g == 0) void'(exp_q0.pop_front());
            else void'(exp_q1.pop_front());
            m_rr   = g;
            m_lock = 1'b0;
         end else begin
            m_lock = hit;
         end
         m_grant = g;
         if (i_valid == 2'b01 && s0 < 4) exp_q0.push_back(i_flit);
         if (i_valid == 2'b10 && s1 < 4) exp_q1.push_back(i_flit);
         if (i_valid == 2'b11) m_err = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [FW-1:0] f, input logic [1:0] r);
      i_valid = v;
      i_flit  = f;
      i_ready = r;
      cycle();
   endtask

   task automatic drain(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) drive(2'b00, '0, 2'b11);
   endtask

   initial begin
      logic [1:0] rv;
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      i_valid  = '0;
      i_ready  = '0;
      i_flit   = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // reset state
      drive(2'b00, '0, 2'b00);

      // single flit, one-cycle latency then empty
      drive(2'b01, 64'hA5, 2'b11);
      drive(2'b00, '0, 2'b11);
      drive(2'b00, '0, 2'b11);

      // fill VC1 to full; fifth push refused while the head stays presented
      for (int i = 0; i < 4; i++) drive(2'b10, 64'h1000 + FW'(i), 2'b00);
      @(negedge clk);
      check_eq("full_o_ready1", FW'(o_ready[1]), FW'(1'b0));
      @(posedge clk);
      #1;
      drive(2'b10, 64'hDEAD, 2'b00);
      drive(2'b00, '0, 2'b00);
      drain(8);

      // round-robin across two VCs with three flits each
      for (int i = 0; i < 3; i++) begin
         drive(2'b01, 64'h2000 + FW'(i), 2'b00);
         drive(2'b10, 64'h3000 + FW'(i), 2'b00);
      end
      vc_log.delete();
      drain(8);
      check_eq("rr_count", FW'(vc_log.size()), FW'(6));
      for (int i = 0; i < 6 && i < vc_log.size(); i++)
         check_eq("rr_order", FW'(vc_log[i]), FW'(i % 2));

      // grant lock on VC0 while only VC1 is ready downstream
      drive(2'b01, 64'h4000, 2'b00);
      drive(2'b10, 64'h4001, 2'b00);
      vc_log.delete();
      for (int i = 0; i < 5; i++) drive(2'b00, '0, 2'b10);
      check_eq("lock_no_transfer", FW'(vc_log.size()), FW'(0));
      drain(4);
      check_eq("lock_count", FW'(vc_log.size()), FW'(2));
      if (vc_log.size() == 2) begin
         check_eq("lock_first", FW'(vc_log[0]), FW'(0));
         check_eq("lock_second", FW'(vc_log[1]), FW'(1));
      end

      // protocol error: dual valid ignored, flag sticks
      drive(2'b01, 64'h5000, 2'b00);
      drive(2'b11, 64'h5001, 2'b00);
      for (int i = 0; i < 3; i++) drive(2'b00, '0, 2'b00);
      drain(4);

      // mid-operation reset discards buffered flits and clears the flag
      drive(2'b01, 64'h6000, 2'b00);
      drive(2'b01, 64'h6001, 2'b00);
      rst_n = 1'b0;
      drive(2'b10, 64'h6002, 2'b11);
      rst_n = 1'b1;
      drive(2'b00, '0, 2'b00);
      drain(4);

      // random traffic with random downstream back-pressure
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0:       rv = 2'b00;
            1:       rv = 2'b01;
            default: rv = 2'b10;
         endcase
         if ($urandom_range(0, 2) == 0) rv = 2'b01 + 2'b01 * 2'($urandom_range(0, 1));
         drive(rv, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
      end
      drain(12);
      drive(2'b00, '0, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tnoc_flit_r2r_link.md
TNOC_FLIT_R2R_LINK -- requirements
Module: tnoc_flit_r2r_link

Interface
REQ-001 Parameter FLIT_WIDTH, default 64, width of one flit payload in bits.
REQ-002 Parameter CHANNELS, default 2, number of virtual channels (1..8).
REQ-003 Parameter DEPTH, default 4, entries per virtual-channel buffer (power of two, 2..16).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-006 i_valid  input  CHANNELS  per-VC upstream valid; at most one bit set per cycle.
REQ-007 o_ready  output  CHANNELS  per-VC upstream ready.
REQ-008 i_flit  input  FLIT_WIDTH  upstream flit, qualified by i_valid.
REQ-009 o_valid  output  CHANNELS  per-VC downstream valid; at most one bit set.
REQ-010 i_ready  input  CHANNELS  per-VC downstream ready.
REQ-011 o_flit  output  FLIT_WIDTH  downstream flit of the VC flagged in o_valid.
REQ-012 o_protocol_error  output  1  sticky flag: upstream drove more than one i_valid bit.

Function
REQ-013 Each VC SHALL own an independent FIFO of DEPTH entries with write pointer, read pointer and count of width clog2(DEPTH)+1.
REQ-014 o_ready[v] SHALL be 1 iff count[v] < DEPTH, from registered state only, with no combinational path from i_ready.
REQ-015 A push to VC v SHALL occur iff i_valid[v] and o_ready[v]; i_flit SHALL be stored at the write pointer, which then increments modulo DEPTH.
REQ-016 When more than one i_valid bit is set, no push SHALL occur in that cycle and o_protocol_error SHALL set and hold until reset.
REQ-017 A full VC SHALL NOT accept a push even if it pops in the same cycle; there is no pass-through.
REQ-018 Minimum latency SHALL be one cycle: a flit pushed in cycle N may appear on o_flit in cycle N+1, never in cycle N.
REQ-019 Output arbitration SHALL be round-robin among non-empty VCs, starting the search at the VC after the last one transferred; the pointer resets to CHANNELS-1, so VC0 has first priority.
REQ-020 The arbiter SHALL consider only FIFO non-empty status; o_valid SHALL NOT depend combinationally on i_ready.
REQ-021 o_valid SHALL be one-hot for the granted VC, or all zero when every FIFO is empty.
REQ-022 o_flit SHALL equal the head entry of the granted VC.
REQ-023 Once o_valid[g] is asserted without i_ready[g], grant g and o_flit SHALL hold unchanged until the transfer completes.
REQ-024 A pop of VC g SHALL occur iff o_valid[g] and i_ready[g]; the read pointer then increments modulo DEPTH.
REQ-025 The round-robin pointer SHALL update to g only on a completed transfer.
REQ-026 When a VC pushes and pops in the same cycle, its count SHALL be unchanged and both pointers SHALL advance.
REQ-027 When o_valid is 0, o_flit is don't-care; the verification bench SHALL NOT check it.
REQ-028 The block SHALL preserve flit order within each VC; it makes no ordering guarantee across VCs.

Reset
REQ-029 While rst_n is 0 at a clock edge, the next state SHALL be:
- all pointers and counts 0;
- round-robin pointer CHANNELS-1;
- grant lock cleared;
- o_protocol_error 0.
REQ-030 Outputs after reset SHALL be o_valid = 0 and o_ready = all ones.
REQ-031 A reset asserted mid-transfer SHALL discard all buffered flits; no flit stored before reset SHALL appear afterwards.
REQ-032 Inputs SHALL be ignored in any cycle in which rst_n is sampled 0.

Verification
REQ-033 The bench SHALL cover the following directed scenarios (defaults, CHANNELS=2, DEPTH=4):
- Single flit: push 0xA5 on VC0 in cycle 1 with i_ready=11 -> o_valid=01 and o_flit=0xA5 in cycle 2; o_valid=00 in cycle 3.
- Fill and full: push 4 flits on VC1 with i_ready=00 -> o_ready[1]=0 after the 4th push; a 5th push with i_valid=10 is not accepted; o_valid=10 holds with the first flit stable throughout.
- Round-robin: both VCs hold 3 flits and i_ready=11 -> output VC order 0,1,0,1,0,1, then o_valid=00.
- Grant lock: VC0 and VC1 both non-empty, grant VC0, i_ready=10 for 5 cycles -> o_valid stays 01 and o_flit stays constant; after i_ready=11, VC0 transfers, then VC1.
- Protocol error: i_valid=11 for one cycle -> no count changes and o_protocol_error=1 from the next cycle until rst_n=0.
- Mid-operation reset: VC0 holds 2 flits, rst_n=0 for one cycle -> o_valid=00 and o_ready=11; no stale flit is ever output afterwards.
